// File: rtl/uart_pkg.sv
// Shared UART constants: byte width (also used on the TX side) and RX buffer defaults.
package uart_pkg;
  localparam int UART_BYTE_W        = 8;
  localparam int UART_RX_ADDR_WIDTH = 6;
  localparam int UART_RX_RTS_MARGIN = 8;
endpackage

// File: rtl/uart_rx_mem.sv
// Simple dual-port RAM with a synchronous write port and a synchronous read port.
// Read-before-write on address collision; the buffer handles collisions with its own bypass.
module uart_rx_mem #(
  parameter int AW = 6,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [0:(1<<AW)-1];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end
endmodule

// File: rtl/uart_rx_buffer.sv
// FWFT circular RX byte buffer: 1-cycle push-to-head latency, head valid the cycle after a pop.
// No backpressure on rx_byte (full drops and sets sticky overflow); UART_RX_FLOW_CTRL_EN adds uart_rts_n.
module uart_rx_buffer
  import uart_pkg::*;
#(
  parameter int ADDR_WIDTH = UART_RX_ADDR_WIDTH
`ifdef UART_RX_FLOW_CTRL_EN
  , parameter int RTS_MARGIN = UART_RX_RTS_MARGIN
`endif
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic [UART_BYTE_W-1:0] rx_byte,
  input  logic                   rx_byte_valid,
  output logic [UART_BYTE_W-1:0] uart_rx_data,
  output logic                   uart_rx_empty,
  input  logic                   uart_rx_rd_en,
  output logic                   rx_full,
  output logic [ADDR_WIDTH:0]    rx_level,
  output logic                   rx_overflow,
  input  logic                   rx_overflow_clr
`ifdef UART_RX_FLOW_CTRL_EN
  , output logic                 uart_rts_n
`endif
);
  localparam int PW    = ADDR_WIDTH + 1;
  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [PW-1:0]          wr_ptr, rd_ptr, wr_next, rd_next, level_next;
  logic                   empty_q, full_q, ovf_q, use_ram_q;
  logic [PW-1:0]          level_q;
  logic [UART_BYTE_W-1:0] data_q, ram_rdata;
  logic                   push_ok, pop_ok, ovf_set, byp;

  always_comb begin
    pop_ok     = uart_rx_rd_en && !empty_q;
    push_ok    = rx_byte_valid && (!full_q || pop_ok);
    ovf_set    = rx_byte_valid && full_q && !pop_ok;
    wr_next    = wr_ptr + PW'(push_ok);
    rd_next    = rd_ptr + PW'(pop_ok);
    level_next = wr_next - rd_next;
    // The pushed byte becomes the new head: RAM cannot return it this edge.
    byp        = push_ok && (wr_ptr[ADDR_WIDTH-1:0] == rd_next[ADDR_WIDTH-1:0]);
  end

  uart_rx_mem #(.AW(ADDR_WIDTH), .DW(UART_BYTE_W)) u_mem (
    .clk   (clk),
    .we    (push_ok),
    .waddr (wr_ptr[ADDR_WIDTH-1:0]),
    .wdata (rx_byte),
    .raddr (rd_next[ADDR_WIDTH-1:0]),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level_q   <= '0;
      empty_q   <= 1'b1;
      full_q    <= 1'b0;
      ovf_q     <= 1'b0;
      data_q    <= '0;
      use_ram_q <= 1'b0;
    end else begin
      wr_ptr  <= wr_next;
      rd_ptr  <= rd_next;
      level_q <= level_next;
      empty_q <= (wr_next == rd_next);
      full_q  <= (level_next == PW'(DEPTH));
      if (ovf_set)              ovf_q <= 1'b1;
      else if (rx_overflow_clr) ovf_q <= 1'b0;
      if (byp) begin
        data_q    <= rx_byte;
        use_ram_q <= 1'b0;
      end else if (pop_ok) begin
        // Popping the last byte: freeze the displayed value instead of stale RAM data.
        if (wr_next == rd_next) begin
          data_q    <= uart_rx_data;
          use_ram_q <= 1'b0;
        end else begin
          use_ram_q <= 1'b1;
        end
      end
    end
  end

  assign uart_rx_data  = use_ram_q ? ram_rdata : data_q;
  assign uart_rx_empty = empty_q;
  assign rx_full       = full_q;
  assign rx_level      = level_q;
  assign rx_overflow   = ovf_q;

`ifdef UART_RX_FLOW_CTRL_EN
  logic [PW-1:0] free_cnt;
  assign free_cnt = PW'(DEPTH) - level_q;

  always_ff @(posedge clk) begin
    if (!resetn)                             uart_rts_n <= 1'b0;
    else if (free_cnt <= PW'(RTS_MARGIN))    uart_rts_n <= 1'b1;
    else if (free_cnt >= PW'(2*RTS_MARGIN))  uart_rts_n <= 1'b0;
  end
`endif
endmodule

// File: tb/tb_uart_rx_buffer.sv
// Directed bench for uart_rx_buffer; flow-control steps are built only with UART_RX_FLOW_CTRL_EN.
module tb_uart_rx_buffer;
  logic       clk = 1'b0;
  logic       resetn;
  logic [7:0] rx_byte;
  logic       rx_byte_valid;
  logic [7:0] uart_rx_data;
  logic       uart_rx_empty;
  logic       uart_rx_rd_en;
  logic       rx_full;
  logic [6:0] rx_level;
  logic       rx_overflow;
  logic       rx_overflow_clr;
`ifdef UART_RX_FLOW_CTRL_EN
  logic       uart_rts_n;
`endif

  int total = 0;
  int bad   = 0;

  uart_rx_buffer dut (
    .clk             (clk),
    .resetn          (resetn),
    .rx_byte         (rx_byte),
    .rx_byte_valid   (rx_byte_valid),
    .uart_rx_data    (uart_rx_data),
    .uart_rx_empty   (uart_rx_empty),
    .uart_rx_rd_en   (uart_rx_rd_en),
    .rx_full         (rx_full),
    .rx_level        (rx_level),
    .rx_overflow     (rx_overflow),
    .rx_overflow_clr (rx_overflow_clr)
`ifdef UART_RX_FLOW_CTRL_EN
    , .uart_rts_n    (uart_rts_n)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, then sample 1ns after the edge.
  task automatic step(input logic v, input logic [7:0] b, input logic rd, input logic clr);
    rx_byte_valid   = v;
    rx_byte         = b;
    uart_rx_rd_en   = rd;
    rx_overflow_clr = clr;
    @(posedge clk);
    #1;
    rx_byte_valid   = 1'b0;
    uart_rx_rd_en   = 1'b0;
    rx_overflow_clr = 1'b0;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    step(1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    resetn = 1'b1;
  endtask

  initial begin
    rx_byte = 8'h00; rx_byte_valid = 1'b0; uart_rx_rd_en = 1'b0; rx_overflow_clr = 1'b0;
    do_reset();
    chk("rst_empty", uart_rx_empty, 1);
    chk("rst_full",  rx_full, 0);
    chk("rst_level", rx_level, 0);
    chk("rst_ovf",   rx_overflow, 0);
    chk("rst_data",  uart_rx_data, 8'h00);

    // single push then pop
    step(1'b1, 8'h41, 1'b0, 1'b0);
    chk("p1_empty", uart_rx_empty, 0);
    chk("p1_data",  uart_rx_data, 8'h41);
    chk("p1_level", rx_level, 1);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("p1_pop_empty", uart_rx_empty, 1);
    chk("p1_pop_level", rx_level, 0);
    chk("p1_hold_data", uart_rx_data, 8'h41);

    // fill, overflow, drain in order
    for (int i = 0; i < 64; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
    chk("fill_full",  rx_full, 1);
    chk("fill_level", rx_level, 64);
    step(1'b1, 8'hAA, 1'b0, 1'b0);
    chk("ovf_set",   rx_overflow, 1);
    chk("ovf_level", rx_level, 64);
    for (int i = 0; i < 64; i++) begin
      chk("drain_data", uart_rx_data, 32'(i));
      step(1'b0, 8'h00, 1'b1, 1'b0);
    end
    chk("drain_empty", uart_rx_empty, 1);
    chk("drain_level", rx_level, 0);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("ovf_clr", rx_overflow, 0);

    // full + simultaneous push/pop
    for (int i = 0; i < 64; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
    step(1'b1, 8'h55, 1'b1, 1'b0);
    chk("pp_full_ovf",   rx_overflow, 0);
    chk("pp_full_level", rx_level, 64);
    chk("pp_full_head",  uart_rx_data, 8'h01);
    for (int i = 1; i < 64; i++) begin
      chk("pp_drain", uart_rx_data, 32'(i));
      step(1'b0, 8'h00, 1'b1, 1'b0);
    end
    chk("pp_last", uart_rx_data, 8'h55);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("pp_empty", uart_rx_empty, 1);

    // level-1 push+pop: the pushed byte becomes head next cycle
    step(1'b1, 8'h11, 1'b0, 1'b0);
    step(1'b1, 8'h22, 1'b1, 1'b0);
    chk("l1pp_data",  uart_rx_data, 8'h22);
    chk("l1pp_level", rx_level, 1);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("l1pp_empty", uart_rx_empty, 1);

    // wrap with MMIO cadence: push, idle, pop
    for (int i = 0; i < 200; i++) begin
      step(1'b1, 8'(i), 1'b0, 1'b0);
      step(1'b0, 8'h00, 1'b0, 1'b0);
      chk("wrap_data",  uart_rx_data, 32'(i & 8'hFF));
      chk("wrap_level", rx_level, 1);
      step(1'b0, 8'h00, 1'b1, 1'b0);
      chk("wrap_empty", uart_rx_empty, 1);
    end

    // pop while empty is ignored
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("pope_level", rx_level, 0);
    chk("pope_empty", uart_rx_empty, 1);
    step(1'b1, 8'h77, 1'b0, 1'b0);
    chk("pope_data",  uart_rx_data, 8'h77);
    chk("pope_lvl1",  rx_level, 1);
    step(1'b0, 8'h00, 1'b1, 1'b0);

    // overflow set beats clear
    for (int i = 0; i < 64; i++) step(1'b1, 8'(i + 8'h80), 1'b0, 1'b0);
    step(1'b1, 8'h99, 1'b0, 1'b1);
    chk("ovf_prio", rx_overflow, 1);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("ovf_clr2", rx_overflow, 0);
    chk("ovf_head", uart_rx_data, 8'h80);

    // mid-stream reset discards contents
    do_reset();
    chk("mrst_empty", uart_rx_empty, 1);
    chk("mrst_level", rx_level, 0);
    chk("mrst_full",  rx_full, 0);
    chk("mrst_data",  uart_rx_data, 8'h00);
    step(1'b1, 8'h5A, 1'b0, 1'b0);
    step(1'b1, 8'h5B, 1'b0, 1'b0);
    chk("mrst_push", uart_rx_data, 8'h5A);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("mrst_next", uart_rx_data, 8'h5B);
    step(1'b0, 8'h00, 1'b1, 1'b0);

`ifdef UART_RX_FLOW_CTRL_EN
    do_reset();
    chk("rts_rst", uart_rts_n, 0);
    for (int i = 0; i < 56; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
    chk("rts_lvl56", rx_level, 56);
    chk("rts_lag", uart_rts_n, 0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    chk("rts_stop", uart_rts_n, 1);
    for (int i = 0; i < 7; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    chk("rts_hyst", uart_rts_n, 1);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("rts_lvl48", rx_level, 48);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    chk("rts_go", uart_rts_n, 0);
    for (int i = 0; i < 20; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
    do_reset();
    chk("rts_mrst", uart_rts_n, 0);
    chk("rts_mrst_empty", uart_rx_empty, 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/uart_rx_buffer.md
Name: uart_rx_buffer

Overview:
- Circular receive buffer between the UART serial receiver (byte strobes) and the MMIO peripheral block, which pops bytes on CPU reads of the RX data register.
- First-word-fall-through: the head byte is always presented with an empty flag, and the consumer pops with a one-cycle rd_en pulse.
- Also provides the fill level, a full flag and a sticky overflow flag for status and debug.

Parameters:
- ADDR_WIDTH, 6, log2 of buffer depth (DEPTH = 2^ADDR_WIDTH = 64 bytes).
- RTS_MARGIN, 8, free-entry threshold for flow control; used only with the optional feature.

Ports:
- clk  in  1  system clock
- resetn  in  1  synchronous reset, active-low
- rx_byte  in  8  byte from the serial receiver
- rx_byte_valid  in  1  one-cycle strobe; rx_byte is valid this cycle
- uart_rx_data  out  8  head byte (FWFT)
- uart_rx_empty  out  1  buffer empty
- uart_rx_rd_en  in  1  pop strobe from the MMIO block
- rx_full  out  1  level == DEPTH
- rx_level  out  ADDR_WIDTH+1  number of stored bytes
- rx_overflow  out  1  sticky; a byte was dropped
- rx_overflow_clr  in  1  clears rx_overflow
- uart_rts_n  out  1  present only with UART_RX_FLOW_CTRL_EN

Behaviour:
- Reset (resetn low at a clk edge):
  - wr_ptr = rd_ptr = 0, rx_level = 0.
  - uart_rx_empty = 1, rx_full = 0, rx_overflow = 0, uart_rx_data = 0x00, uart_rts_n = 0.
  - Buffer contents are not cleared.
  - A reset that arrives mid-stream discards all stored bytes; the first push after reset lands at index 0.
- Pointers:
  - ADDR_WIDTH+1 bits each; the MSB distinguishes full from empty.
  - Empty = (wr_ptr == rd_ptr).
  - Full = index bits equal and MSBs differ.
  - Pointers wrap naturally modulo 2^(ADDR_WIDTH+1).
- Push:
  - rx_byte_valid and not full: write rx_byte at wr_ptr index, wr_ptr+1.
  - Full and no simultaneous pop: drop the byte, set rx_overflow, leave the pointers unchanged.
- Pop:
  - uart_rx_rd_en and not empty: rd_ptr+1.
  - Pop while empty: ignored; no pointer or flag change.
- Simultaneous push and pop:
  - Both take effect, rx_level is unchanged, and there is no overflow even when full.
  - When the buffer was empty, the pop is ignored and the push is accepted, giving level 1.
- Output timing:
  - All outputs are registered and update at the same edge as the pointer change.
  - After a push to an empty buffer at edge E, uart_rx_empty = 0 and uart_rx_data = the pushed byte during the cycle after E (1-cycle latency).
  - After a pop at edge E, uart_rx_data shows the next byte in the cycle after E. This is required because the MMIO block can sample a new read two cycles after its rd_en pulse.
  - The storage RAM has synchronous read, so the implementation reads the next-head address (rd_ptr or rd_ptr+1) so the head register is correct one cycle after E.
  - A push into an empty buffer bypasses the RAM directly into the head register.
- When empty, uart_rx_data holds its last value. It is don't-care to consumers.
- rx_level = wr_ptr - rd_ptr (ADDR_WIDTH+1 bit subtraction), registered.
- rx_overflow:
  - Set has priority over rx_overflow_clr in the same cycle.
  - Otherwise rx_overflow_clr clears it.

Optional Feature:
- Macro: UART_RX_FLOW_CTRL_EN.
- Defined:
  - uart_rts_n is registered; it goes to 1 (stop sender) when free entries (DEPTH - rx_level) <= RTS_MARGIN.
  - It returns to 0 when free entries >= 2*RTS_MARGIN (hysteresis).
  - It updates one cycle after the level change.
- Undefined: the uart_rts_n port and its logic are absent, and RTS_MARGIN is unused.

Decomposition:
- Shared package/include uart_pkg holds:
  - UART_RX_ADDR_WIDTH default (6) and UART_RX_RTS_MARGIN default (8).
  - The byte-width constant (8), shared with the TX side.
- One sub-module, uart_rx_mem: simple dual-port RAM, DEPTH x 8, with a synchronous write port and a synchronous read port, inferable as iCE40 block RAM.
- Pointer, level, flag and head-register logic stays in uart_rx_buffer.

Test Plan:
1. Reset, then push 0x41 -> one cycle later: uart_rx_empty=0, uart_rx_data=0x41, rx_level=1. Pop -> next cycle: empty=1, level=0.
2. Push 0x00..0x3F (64 bytes) -> rx_full=1, level=64. Push 0xAA -> rx_overflow=1, level stays 64. Pop all 64 -> data sequence 0x00..0x3F in order, 0xAA never seen.
3. Fill to 64, then push 0x55 and pop in the same cycle -> no overflow, level=64. After draining 63 more pops, the last byte read is 0x55.
4. Wrap: 200 push/pop pairs with values i&0xFF, one pop after each push with rd_en two cycles after each push (MMIO cadence) -> every byte matches, pointers wrap cleanly, level ≤ 1.
5. Pop while empty, and rx_overflow_clr with a simultaneous overflow -> pointers unchanged; rx_overflow stays 1. Then clr alone -> 0.
6. With UART_RX_FLOW_CTRL_EN, default parameters:
   - Fill to 56 -> uart_rts_n=1 one cycle after the 56th push.
   - Drain to 48 -> rts_n=0 one cycle after reaching 48.
   - Mid-fill reset -> rts_n=0, empty=1.
